// File: rtl/peak_detector.sv
// Post-trigger window peak finder for the signed ADC stream; feeds the scaler's peak_in port.
// Config bus: gpio_in[31]=write strobe, [30:16]=address, [15:0]=data. Define PEAK_ABS_EN to search on magnitude.
module peak_detector #(
  parameter int bus_addr = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             gpio_in,
  input  logic signed [15:0]      adc_data,
  input  logic                    adc_valid,
  input  logic                    trigger,
  output logic signed [15:0]      peak_out,
  output logic                    peak_out_valid,
  output logic [CNT_W-1:0]        peak_idx,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SEARCH, S_EMIT} state_t;

  // cfg_val[0] = delay, cfg_val[1] = window length
  logic [15:0] cfg_val [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      logic [15:0] val_reg;
      logic        hit;
      assign hit = gpio_in[31] && (gpio_in[30:16] == 15'(bus_addr + gi));
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     val_reg <= '0;
        else if (hit) val_reg <= gpio_in[15:0];
      end
      assign cfg_val[gi] = val_reg;
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CNT_W-1:0]      dly_snap_reg, dly_snap_next;
  logic [CNT_W-1:0]      win_snap_reg, win_snap_next;
  logic signed [15:0]    max_reg, max_next;
  logic [CNT_W-1:0]      idx_reg, idx_next;
  logic signed [15:0]    peak_out_reg, peak_out_next;
  logic [CNT_W-1:0]      peak_idx_reg, peak_idx_next;
  logic                  overrun_reg, overrun_next;

  logic signed [15:0]    key;
  logic                  better;
  logic                  accept_trig;

`ifdef PEAK_ABS_EN
  always_comb begin
    if (adc_data == -16'sd32768) key = 16'sd32767;
    else if (adc_data < 0)       key = -adc_data;
    else                         key = adc_data;
  end
`else
  assign key = adc_data;
`endif

  // First window sample always loads; later ones only on strictly greater so ties keep the earliest.
  assign better = (cnt_reg == '0) || (key > max_reg);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dly_snap_next = dly_snap_reg;
    win_snap_next = win_snap_reg;
    max_next      = max_reg;
    idx_next      = idx_reg;
    peak_out_next = peak_out_reg;
    peak_idx_next = peak_idx_reg;
    overrun_next  = overrun_reg;
    accept_trig   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (trigger) accept_trig = 1'b1;
      end
      S_DELAY: begin
        if (trigger) overrun_next = 1'b1;
        if (adc_valid) begin
          if (cnt_reg + CNT_W'(1) == dly_snap_reg) begin
            cnt_next   = '0;
            state_next = S_SEARCH;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S_SEARCH: begin
        if (trigger) overrun_next = 1'b1;
        if (adc_valid) begin
          if (better) begin
            max_next = key;
            idx_next = cnt_reg;
          end
          if (cnt_reg + CNT_W'(1) == win_snap_reg) begin
            peak_out_next = better ? key : max_reg;
            peak_idx_next = better ? cnt_reg : idx_reg;
            cnt_next      = '0;
            state_next    = S_EMIT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S_EMIT: begin
        state_next = S_IDLE;
        if (trigger) accept_trig = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (accept_trig) begin
      dly_snap_next = CNT_W'(cfg_val[0]);
      win_snap_next = (cfg_val[1] == 16'd0) ? CNT_W'(1) : CNT_W'(cfg_val[1]);
      cnt_next      = '0;
      state_next    = (cfg_val[0] == 16'd0) ? S_SEARCH : S_DELAY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      dly_snap_reg <= '0;
      win_snap_reg <= '0;
      max_reg      <= '0;
      idx_reg      <= '0;
      peak_out_reg <= '0;
      peak_idx_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dly_snap_reg <= dly_snap_next;
      win_snap_reg <= win_snap_next;
      max_reg      <= max_next;
      idx_reg      <= idx_next;
      peak_out_reg <= peak_out_next;
      peak_idx_reg <= peak_idx_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign peak_out       = peak_out_reg;
  assign peak_idx       = peak_idx_reg;
  assign peak_out_valid = (state_reg == S_EMIT);
  assign busy           = (state_reg != S_IDLE);
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_peak_detector.sv
// Scoreboard bench for peak_detector: stimulus pushes model results, a negedge monitor pops on each strobe.
module tb_peak_detector;
  localparam int BASE = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        gpio_in;
  logic signed [15:0] adc_data;
  logic               adc_valid;
  logic               trigger;
  logic signed [15:0] peak_out;
  logic               peak_out_valid;
  logic [15:0]        peak_idx;
  logic               busy;
  logic               overrun;

  peak_detector #(.bus_addr(BASE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .adc_data(adc_data),
    .adc_valid(adc_valid), .trigger(trigger), .peak_out(peak_out),
    .peak_out_valid(peak_out_valid), .peak_idx(peak_idx),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int pk; int idx; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_delay = 0, m_win = 0;
  int snap_dly = 0, snap_win = 1;
  int exp_overrun = 0;
  int last_pk = 0, last_idx = 0;
  int vals[$];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int key_of(input int v);
`ifdef PEAK_ABS_EN
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int addr, input int data);
    gpio_in = {1'b1, 15'(BASE + addr), 16'(data)};
    step();
    gpio_in = '0;
    if (addr == 0) m_delay = data; else m_win = data;
  endtask

  task automatic trig();
    trigger   = 1'b1;
    adc_valid = 1'($urandom % 2);
    adc_data  = 16'($urandom);
    snap_dly  = m_delay;
    snap_win  = (m_win == 0) ? 1 : m_win;
    step();
    trigger   = 1'b0;
    adc_valid = 1'b0;
  endtask

  // Drives vals (delay + window samples); returns in the strobe cycle.
  task automatic feed(input int gap_mode, input int mid_trig, input int mid_cfg);
    int mx, ix, k, gaps;
    exp_t e;
    for (int i = 0; i < vals.size(); i++) begin
      gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        adc_valid = 1'b0;
        adc_data  = 16'($urandom);
        step();
      end
      adc_valid = 1'b1;
      adc_data  = 16'(vals[i]);
      trigger   = (i == mid_trig);
      if (i == mid_cfg) begin
        gpio_in = {1'b1, 15'(BASE), 16'd7};
        m_delay = 7;
      end
      step();
      trigger   = 1'b0;
      adc_valid = 1'b0;
      gpio_in   = '0;
    end
    if (mid_trig >= 0) exp_overrun = 1;
    mx = key_of(vals[snap_dly]);
    for (int i = 0; i < snap_win; i++) begin
      k = key_of(vals[snap_dly + i]);
      if (k > mx) mx = k;
    end
    ix = -1;
    for (int i = 0; i < snap_win && ix < 0; i++)
      if (key_of(vals[snap_dly + i]) == mx) ix = i;
    e.pk = mx; e.idx = ix; e.cyc = cyc;
    exp_q.push_back(e);
    last_pk = mx; last_idx = ix;
    chk("busy_emit", int'(busy), 1);
    chk("overrun", int'(overrun), exp_overrun);
  endtask

  task automatic idle_after();
    step();
    chk("busy_idle", int'(busy), 0);
    chk("peak_hold", int'(peak_out), last_pk);
    chk("idx_hold", int'(peak_idx), last_idx);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && peak_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got peak %0d idx %0d expected no strobe (cycle %0d)",
                 peak_out, peak_idx, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("peak_out", int'(peak_out), e.pk);
        chk("peak_idx", int'(peak_idx), e.idx);
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n, chained, mt;
    rst = 1'b0; gpio_in = '0; adc_data = '0; adc_valid = 1'b0; trigger = 1'b0;
    step(); step();
    chk("rst_peak_out", int'(peak_out), 0);
    chk("rst_valid", int'(peak_out_valid), 0);
    chk("rst_idx", int'(peak_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    step();

    // Basic window, tie keeps earliest
    cfg(0, 2); cfg(1, 4);
    trig(); vals = '{5, 7, 3, 9, -1, 9}; feed(0, -1, -1); idle_after();

    // Zero delay, window 1 and window 0
    cfg(0, 0); cfg(1, 1);
    trig(); vals = '{-20}; feed(0, -1, -1); idle_after();
    cfg(1, 0);
    trig(); vals = '{-20}; feed(0, -1, -1); idle_after();

    // Alternating valid, then a trigger on the strobe cycle
    cfg(0, 1); cfg(1, 3);
    trig(); vals = '{1, 4, 2, 8}; feed(1, -1, -1);
    trig(); vals = '{0, -1, -7, -3}; feed(0, -1, -1); idle_after();

    // Trigger mid-search plus config write mid-window
    cfg(0, 1); cfg(1, 4);
    trig(); vals = '{10, -5, 20, 20, 3}; feed(0, 2, 3); idle_after();

    // Reset mid-search
    cfg(0, 0); cfg(1, 5);
    trig();
    adc_valid = 1'b1; adc_data = 16'sd500; step();
    adc_data = 16'sd600; step();
    adc_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_peak_out", int'(peak_out), 0);
    chk("mid_rst_valid", int'(peak_out_valid), 0);
    chk("mid_rst_idx", int'(peak_idx), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    m_delay = 0; m_win = 0; exp_overrun = 0;
    step(); step();
    rst = 1'b1;
    step();
    cfg(0, 1); cfg(1, 2);
    trig(); vals = '{3, -4, 6}; feed(2, -1, -1); idle_after();

    // Full-scale negative sample
    cfg(0, 0); cfg(1, 3);
    trig(); vals = '{100, -32768, -200}; feed(0, -1, -1); idle_after();

    // Randomized windows
    chained = 0;
    for (int t = 0; t < 40; t++) begin
      if (!chained) begin
        cfg(0, int'($urandom_range(0, 4)));
        cfg(1, int'($urandom_range(0, 6)));
      end
      trig();
      n = snap_dly + snap_win;
      vals = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom % 4)
          0: vals.push_back(int'($urandom_range(0, 4)) - 2);
          1: vals.push_back(($urandom % 2) ? -32768 : 32767);
          default: vals.push_back(int'($urandom_range(0, 65535)) - 32768);
        endcase
      end
      mt = ($urandom % 6 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      feed(int'($urandom_range(0, 2)), mt, -1);
      chained = ($urandom % 4 == 0);
      if (!chained) idle_after();
    end

    step(); step(); step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
